// File: rtl/icache_dm.sv
// icache_dm: direct-mapped, read-only instruction cache.
// 2**INDEX_W sets of 16-byte lines (4 words), physical tags.
// Hits return data one cycle after acceptance.
// Misses refill a whole line from the bridge, then return the requested word.
// Optional build macro ICACHE_PERF_CNT_EN enables the hit/miss counters.
// When the macro is undefined, hit_cnt and miss_cnt are tied to 0.
module icache_dm #(
    parameter int INDEX_W = 8,
    parameter int TAG_W   = 20
) (
    input  logic               clk,
    input  logic               resetn,
    // fetch side
    input  logic               req,
    input  logic [INDEX_W-1:0] vindex,
    input  logic [3:0]         voffset,
    input  logic [TAG_W-1:0]   ptag,
    output logic               addr_ok,
    output logic               data_ok,
    output logic [31:0]        rdata,
    // bridge read channel
    output logic               rd_req,
    output logic [2:0]         rd_type,
    output logic [31:0]        rd_addr,
    input  logic               rd_rdy,
    input  logic               ret_valid,
    input  logic               ret_last,
    input  logic [31:0]        ret_data,
    // performance counters
    output logic [31:0]        hit_cnt,
    output logic [31:0]        miss_cnt
);

    localparam int SETS = 1 << INDEX_W;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_MISS   = 3'd2;
    localparam logic [2:0] S_REFILL = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    logic [2:0]         state_reg, state_next;
    logic [INDEX_W-1:0] index_reg;
    logic [1:0]         word_reg;
    logic [TAG_W-1:0]   ptag_reg;

    logic [SETS-1:0]    valid_reg;
    logic [TAG_W-1:0]   tag_mem  [SETS];
    logic [127:0]       data_mem [SETS];
    logic [127:0]       line_rd_reg;

    logic [31:0]        buf_reg [4];
    logic [1:0]         cnt_reg;
    logic [31:0]        rdata_reg;

    logic               hit;
    logic               accept;
    logic               fill_done;
    logic [127:0]       line_wr;
    logic [31:0]        word_out;

    assign hit       = (state_reg == S_LOOKUP) && valid_reg[index_reg]
                       && (tag_mem[index_reg] == ptag_reg);
    assign addr_ok   = (state_reg == S_IDLE) || hit;
    assign accept    = req && addr_ok;
    assign data_ok   = hit || (state_reg == S_RESP);
    assign fill_done = (state_reg == S_REFILL) && ret_valid && ret_last;

    // The line written on the final beat merges the beat in flight with the buffer.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_line_wr
            assign line_wr[gi*32 +: 32] = (cnt_reg == 2'(gi)) ? ret_data : buf_reg[gi];
        end
    endgenerate

    // Select the returned word: the array line on a hit, the refill buffer in RESP.
    always_comb begin
        word_out = buf_reg[word_reg];
        if (hit) begin
            word_out = line_rd_reg[{word_reg, 5'b0} +: 32];
        end
    end

    assign rdata   = data_ok ? word_out : rdata_reg;
    // Gated by resetn so that the request drops in the reset cycle itself.
    assign rd_req  = resetn && (state_reg == S_MISS);
    assign rd_type = 3'b100;
    assign rd_addr = {ptag_reg, index_reg, 4'b0000};

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (req) state_next = S_LOOKUP;
            S_LOOKUP: begin
                if (!hit)      state_next = S_MISS;
                else if (!req) state_next = S_IDLE;
            end
            S_MISS:   if (rd_rdy) state_next = S_REFILL;
            S_REFILL: if (ret_valid && ret_last) state_next = S_RESP;
            S_RESP:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) state_reg <= S_IDLE;
        else         state_reg <= state_next;
    end

    // Capture the request address fields on acceptance.
    always_ff @(posedge clk) begin
        if (accept) begin
            index_reg <= vindex;
            word_reg  <= voffset[3:2];
            ptag_reg  <= ptag;
        end
    end

    // Refill beat counter: restarts when the bridge takes the request.
    always_ff @(posedge clk) begin
        if (!resetn)                                 cnt_reg <= 2'd0;
        else if (state_reg == S_MISS && rd_rdy)      cnt_reg <= 2'd0;
        else if (state_reg == S_REFILL && ret_valid) cnt_reg <= cnt_reg + 2'd1;
    end

    // Collect returned words into the refill buffer.
    always_ff @(posedge clk) begin
        if (state_reg == S_REFILL && ret_valid) buf_reg[cnt_reg] <= ret_data;
    end

    // Valid bits: cleared by reset, set when a line fill completes.
    always_ff @(posedge clk) begin
        if (!resetn)        valid_reg <= '0;
        else if (fill_done) valid_reg[index_reg] <= 1'b1;
    end

    // Tag array written at the end of a fill.
    always_ff @(posedge clk) begin
        if (fill_done) tag_mem[index_reg] <= ptag_reg;
    end

    // Line data array: synchronous read on accept, write at the end of a fill.
    always_ff @(posedge clk) begin
        if (fill_done) data_mem[index_reg] <= line_wr;
        if (accept)    line_rd_reg <= data_mem[vindex];
    end

    // Hold the last delivered word while data_ok is low.
    always_ff @(posedge clk) begin
        if (!resetn)      rdata_reg <= 32'd0;
        else if (data_ok) rdata_reg <= word_out;
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_reg, miss_cnt_reg;

    // Count lookup hits and lookup-to-miss transitions.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hit_cnt_reg  <= 32'd0;
            miss_cnt_reg <= 32'd0;
        end else if (state_reg == S_LOOKUP) begin
            if (hit) hit_cnt_reg  <= hit_cnt_reg + 32'd1;
            else     miss_cnt_reg <= miss_cnt_reg + 32'd1;
        end
    end

    assign hit_cnt  = hit_cnt_reg;
    assign miss_cnt = miss_cnt_reg;
`else
    assign hit_cnt  = 32'd0;
    assign miss_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Directed testbench for icache_dm: cold miss, hit streaming, conflict miss,
// refill backpressure, reset during refill, and the performance counters.
module tb_icache_dm;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req;
    logic [7:0]  vindex;
    logic [3:0]  voffset;
    logic [19:0] ptag;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;
    logic        rd_req;
    logic [2:0]  rd_type;
    logic [31:0] rd_addr;
    logic        rd_rdy, ret_valid, ret_last;
    logic [31:0] ret_data;
    logic [31:0] hit_cnt, miss_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;

    icache_dm dut (
        .clk(clk), .resetn(resetn),
        .req(req), .vindex(vindex), .voffset(voffset), .ptag(ptag),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    // Safety net against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full miss sequence from IDLE: request, lookup miss, optional rd_rdy stall,
    // four return beats, then the response cycle.
    task automatic do_miss(input logic [19:0] t, input logic [7:0] idx,
                           input logic [3:0] off, input int wait_n,
                           input logic [31:0] base, input bit hold);
        logic [31:0] exp_addr;
        logic [31:0] exp_word;
        exp_addr = {t, idx, 4'h0};
        exp_word = base + 32'(off[3:2]);
        req = 1'b1; ptag = t; vindex = idx; voffset = off;
        #1 chk("miss_accept_addr_ok", 32'(addr_ok), 32'd1);
        tick();
        if (!hold) req = 1'b0;
        #1 chk("lookup_miss_data_ok", 32'(data_ok), 32'd0);
        chk("lookup_miss_addr_ok", 32'(addr_ok), 32'd0);
        tick();
        for (int i = 0; i < wait_n; i++) begin
            #1 chk("stall_rd_req", 32'(rd_req), 32'd1);
            chk("stall_rd_addr", rd_addr, exp_addr);
            chk("stall_addr_ok", 32'(addr_ok), 32'd0);
            tick();
        end
        rd_rdy = 1'b1;
        #1 chk("rd_req", 32'(rd_req), 32'd1);
        chk("rd_addr", rd_addr, exp_addr);
        chk("rd_type", 32'(rd_type), 32'd4);
        tick();
        rd_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ret_valid = 1'b1; ret_data = base + 32'(i); ret_last = (i == 3);
            #1 chk("refill_addr_ok", 32'(addr_ok), 32'd0);
            chk("refill_rd_req", 32'(rd_req), 32'd0);
            tick();
        end
        ret_valid = 1'b0; ret_last = 1'b0;
        #1 chk("resp_data_ok", 32'(data_ok), 32'd1);
        chk("resp_rdata", rdata, exp_word);
        chk("resp_addr_ok", 32'(addr_ok), 32'd0);
        req = 1'b0;
        tick();
        #1 chk("idle_data_ok", 32'(data_ok), 32'd0);
        chk("idle_rdata_hold", rdata, exp_word);
    endtask

    initial begin
        resetn = 1'b0; req = 1'b0; vindex = '0; voffset = '0; ptag = '0;
        rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0; ret_data = '0;
        tick(); tick();
        resetn = 1'b1;
        #1 chk("rst_addr_ok", 32'(addr_ok), 32'd1);
        chk("rst_data_ok", 32'(data_ok), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rd_req", 32'(rd_req), 32'd0);
        chk("rst_hit_cnt", hit_cnt, 32'd0);
        chk("rst_miss_cnt", miss_cnt, 32'd0);
        tick();

        // Cold miss: rd_rdy after 2 cycles, words A0..A3, requested word 1.
        do_miss(20'h1c000, 8'h00, 4'h4, 2, 32'hA0, 1'b0);

        // Hit streaming: one request per cycle, data one cycle later.
        for (int k = 0; k < 4; k++) begin
            req = 1'b1; ptag = 20'h1c000; vindex = 8'h00; voffset = 4'(k * 4);
            #1 chk("stream_addr_ok", 32'(addr_ok), 32'd1);
            chk("stream_rd_req", 32'(rd_req), 32'd0);
            if (k > 0) begin
                chk("stream_data_ok", 32'(data_ok), 32'd1);
                chk("stream_rdata", rdata, 32'hA0 + 32'(k - 1));
            end
            tick();
        end
        req = 1'b0;
        #1 chk("stream_last_data_ok", 32'(data_ok), 32'd1);
        chk("stream_last_rdata", rdata, 32'hA3);
        chk("stream_last_rd_req", 32'(rd_req), 32'd0);
        tick();
`ifdef ICACHE_PERF_CNT_EN
        chk("perf_hit_cnt", hit_cnt, 32'd4);
        chk("perf_miss_cnt", miss_cnt, 32'd1);
`else
        chk("perf_hit_cnt", hit_cnt, 32'd0);
        chk("perf_miss_cnt", miss_cnt, 32'd0);
`endif

        // Conflict miss evicts tag 1c000 from set 0.
        do_miss(20'h1c001, 8'h00, 4'h8, 0, 32'hB0, 1'b0);
        req = 1'b1; ptag = 20'h1c001; vindex = 8'h00; voffset = 4'h4;
        tick();
        req = 1'b0;
        #1 chk("conflict_hit_data_ok", 32'(data_ok), 32'd1);
        chk("conflict_hit_rdata", rdata, 32'hB1);
        tick();

        // Old tag misses again; rd_rdy held low 10 cycles with req held.
        do_miss(20'h1c000, 8'h00, 4'hC, 10, 32'hC0, 1'b1);

        // Reset in the middle of a refill.
        req = 1'b1; ptag = 20'h1c002; vindex = 8'h05; voffset = 4'h0;
        tick();
        req = 1'b0;
        tick();
        rd_rdy = 1'b1;
        tick();
        rd_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ret_valid = 1'b1; ret_data = 32'hD0 + 32'(i); ret_last = 1'b0;
            tick();
        end
        ret_valid = 1'b0;
        resetn = 1'b0;
        tick();
        #1 chk("rst_mid_addr_ok", 32'(addr_ok), 32'd1);
        chk("rst_mid_rd_req", 32'(rd_req), 32'd0);
        chk("rst_mid_data_ok", 32'(data_ok), 32'd0);
        chk("rst_mid_miss_cnt", miss_cnt, 32'd0);
        resetn = 1'b1;
        tick();
        // Set 0 was valid before reset; it must now miss.
        req = 1'b1; ptag = 20'h1c000; vindex = 8'h00; voffset = 4'h0;
        tick();
        req = 1'b0;
        #1 chk("post_rst_data_ok", 32'(data_ok), 32'd0);
        chk("post_rst_addr_ok", 32'(addr_ok), 32'd0);
        tick();
        #1 chk("post_rst_rd_req", 32'(rd_req), 32'd1);
        chk("post_rst_rd_addr", rd_addr, 32'h1c000000);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
